// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file write-back arbiter.
package wb_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned REG_DATA_W = 32;
   localparam int unsigned PEND_W     = 3;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] data;
   } wb_entry_t;

   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_MEM = 1'b1
   } wb_req_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request, operand read and register-file write port bundle.
interface regfile_wb_arbiter_if;
   import wb_pkg::*;

   logic                  alu_req;
   logic [REG_ADDR_W-1:0] alu_dir;
   logic [REG_DATA_W-1:0] alu_di;
   logic                  alu_gnt;
   logic                  mem_req;
   logic [REG_ADDR_W-1:0] mem_dir;
   logic [REG_DATA_W-1:0] mem_di;
   logic                  mem_gnt;
   logic                  rd_req;
   logic [REG_ADDR_W-1:0] rd_dir_a;
   logic [REG_ADDR_W-1:0] rd_dir_b;
   logic                  hazard;
   logic                  reg_rd;
   logic [REG_ADDR_W-1:0] dir_wra;
   logic [REG_DATA_W-1:0] di;
   logic                  reg_wr;
   logic [PEND_W-1:0]     pending;

   modport master (
      output alu_req, alu_dir, alu_di, mem_req, mem_dir, mem_di,
             rd_req, rd_dir_a, rd_dir_b,
      input  alu_gnt, mem_gnt, hazard, reg_rd, dir_wra, di, reg_wr, pending
   );

   modport slave (
      input  alu_req, alu_dir, alu_di, mem_req, mem_dir, mem_di,
             rd_req, rd_dir_a, rd_dir_b,
      output alu_gnt, mem_gnt, hazard, reg_rd, dir_wra, di, reg_wr, pending
   );

endinterface

// File: rtl/wb_queue.sv
// Per-requester write FIFO with per-entry address match outputs.
module wb_queue
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_push,
   input  wb_entry_t               i_entry,
   input  logic                    i_pop,
   output wb_entry_t               o_head,
   output logic                    o_full,
   output logic                    o_empty,
   output logic [$clog2(DEPTH):0]  o_count,
   input  logic [REG_ADDR_W-1:0]   i_cmp_wr,
   input  logic [REG_ADDR_W-1:0]   i_cmp_rd_a,
   input  logic [REG_ADDR_W-1:0]   i_cmp_rd_b,
   output logic [DEPTH-1:0]        o_hit_wr,
   output logic [DEPTH-1:0]        o_hit_rd_a,
   output logic [DEPTH-1:0]        o_hit_rd_b
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   wb_entry_t        r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;
   logic [DEPTH-1:0] w_valid;

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rptr];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_entry;
   end

   // An entry is live when its distance from the read pointer is below the fill count.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
      logic [PTR_W-1:0] w_off;
      assign w_off          = PTR_W'(gi) - r_rptr;
      assign w_valid[gi]    = (CNT_W'(w_off) < r_count);
      assign o_hit_wr[gi]   = w_valid[gi] & (r_mem[gi].addr == i_cmp_wr);
      assign o_hit_rd_a[gi] = w_valid[gi] & (r_mem[gi].addr == i_cmp_rd_a);
      assign o_hit_rd_b[gi] = w_valid[gi] & (r_mem[gi].addr == i_cmp_rd_b);
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for ALU and MEM results with read-hazard detection.
// Build option WB_ZERO_GUARD_EN: writes to r0 are acknowledged but dropped, and r0 never hazards.
module regfile_wb_arbiter
   import wb_pkg::*;
#(
   parameter int unsigned QDEPTH = 2
) (
   input logic           clk,
   input logic           rst_n,
   regfile_wb_arbiter_if.slave bus
);

   localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;
   localparam int unsigned SUM_W = CNT_W + 2;

   logic                  r_reg_wr;
   logic [REG_ADDR_W-1:0] r_dir_wra;
   logic [REG_DATA_W-1:0] r_di;
   wb_req_e               r_last;

   wb_entry_t             w_alu_head, w_mem_head;
   logic                  w_alu_full, w_mem_full;
   logic                  w_alu_empty, w_mem_empty;
   logic [CNT_W-1:0]      w_alu_cnt, w_mem_cnt;
   logic [QDEPTH-1:0]     w_alu_hit_wr, w_alu_hit_a, w_alu_hit_b;
   logic [QDEPTH-1:0]     w_mem_hit_wr, w_mem_hit_a, w_mem_hit_b;
   logic                  w_alu_zero, w_mem_zero, w_rd_a_zero, w_rd_b_zero;
   logic                  w_alu_push, w_mem_push;
   logic                  w_pop_alu, w_pop_mem, w_sel_alu;
   logic                  w_slot_alu_blk, w_slot_mem_blk;
   logic                  w_rd_a_hit, w_rd_b_hit;
   logic [SUM_W-1:0]      w_sum;

`ifdef WB_ZERO_GUARD_EN
   assign w_alu_zero  = (bus.alu_dir  == '0);
   assign w_mem_zero  = (bus.mem_dir  == '0);
   assign w_rd_a_zero = (bus.rd_dir_a == '0);
   assign w_rd_b_zero = (bus.rd_dir_b == '0);
`else
   assign w_alu_zero  = 1'b0;
   assign w_mem_zero  = 1'b0;
   assign w_rd_a_zero = 1'b0;
   assign w_rd_b_zero = 1'b0;
`endif

   // Own-queue order is kept by the FIFO; only the other requester's writes can reorder.
   assign w_slot_alu_blk = r_reg_wr & (r_last == REQ_MEM) & (r_dir_wra == bus.alu_dir);
   assign w_slot_mem_blk = r_reg_wr & (r_last == REQ_ALU) & (r_dir_wra == bus.mem_dir);
   assign bus.alu_gnt    = ~w_alu_full & ~(|w_mem_hit_wr) & ~w_slot_alu_blk;
   assign bus.mem_gnt    = ~w_mem_full & ~(|w_alu_hit_wr) & ~w_slot_mem_blk;
   assign w_alu_push     = bus.alu_req & bus.alu_gnt & ~w_alu_zero;
   assign w_mem_push     = bus.mem_req & bus.mem_gnt & ~w_mem_zero;

   assign w_sel_alu = ~w_alu_empty & (w_mem_empty | (r_last == REQ_MEM));
   assign w_pop_alu = w_sel_alu;
   assign w_pop_mem = ~w_mem_empty & ~w_sel_alu;

   wb_queue #(.DEPTH(QDEPTH)) u_alu_q (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_push     (w_alu_push),
      .i_entry    ({bus.alu_dir, bus.alu_di}),
      .i_pop      (w_pop_alu),
      .o_head     (w_alu_head),
      .o_full     (w_alu_full),
      .o_empty    (w_alu_empty),
      .o_count    (w_alu_cnt),
      .i_cmp_wr   (bus.mem_dir),
      .i_cmp_rd_a (bus.rd_dir_a),
      .i_cmp_rd_b (bus.rd_dir_b),
      .o_hit_wr   (w_alu_hit_wr),
      .o_hit_rd_a (w_alu_hit_a),
      .o_hit_rd_b (w_alu_hit_b)
   );

   wb_queue #(.DEPTH(QDEPTH)) u_mem_q (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_push     (w_mem_push),
      .i_entry    ({bus.mem_dir, bus.mem_di}),
      .i_pop      (w_pop_mem),
      .o_head     (w_mem_head),
      .o_full     (w_mem_full),
      .o_empty    (w_mem_empty),
      .o_count    (w_mem_cnt),
      .i_cmp_wr   (bus.alu_dir),
      .i_cmp_rd_a (bus.rd_dir_a),
      .i_cmp_rd_b (bus.rd_dir_b),
      .o_hit_wr   (w_mem_hit_wr),
      .o_hit_rd_a (w_mem_hit_a),
      .o_hit_rd_b (w_mem_hit_b)
   );

   // Issue slot; r_last also records which requester owns the slot contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_reg_wr  <= 1'b0;
         r_dir_wra <= '0;
         r_di      <= '0;
         r_last    <= REQ_MEM;
      end else begin
         r_reg_wr <= w_pop_alu | w_pop_mem;
         if (w_pop_alu) begin
            r_dir_wra <= w_alu_head.addr;
            r_di      <= w_alu_head.data;
            r_last    <= REQ_ALU;
         end else if (w_pop_mem) begin
            r_dir_wra <= w_mem_head.addr;
            r_di      <= w_mem_head.data;
            r_last    <= REQ_MEM;
         end
      end
   end

   assign w_rd_a_hit = (|w_alu_hit_a) | (|w_mem_hit_a) | (r_reg_wr & (r_dir_wra == bus.rd_dir_a));
   assign w_rd_b_hit = (|w_alu_hit_b) | (|w_mem_hit_b) | (r_reg_wr & (r_dir_wra == bus.rd_dir_b));
   assign bus.hazard = bus.rd_req & ((w_rd_a_hit & ~w_rd_a_zero) | (w_rd_b_hit & ~w_rd_b_zero));
   assign bus.reg_rd = bus.rd_req & ~bus.hazard;

   assign w_sum       = SUM_W'(w_alu_cnt) + SUM_W'(w_mem_cnt) + SUM_W'(r_reg_wr);
   assign bus.pending = (w_sum > SUM_W'(7)) ? PEND_W'(7) : PEND_W'(w_sum);
   assign bus.reg_wr  = r_reg_wr;
   assign bus.dir_wra = r_dir_wra;
   assign bus.di      = r_di;

endmodule
